// File: rtl/mux_scan_sequencer_pkg.sv
// mux_scan_sequencer_pkg: shared FSM state encoding and channel count for the mux scan sequencer
package mux_scan_sequencer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;
  localparam int NCH = 8;
endpackage

// File: rtl/mux_8to1.sv
// mux_8to1: combinational 8-to-1 mux; {s0,s1,s2} selects i0..i7 onto y (s0 is the MSB)
module mux_8to1 (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic i4,
  input  logic i5,
  input  logic i6,
  input  logic i7,
  input  logic s0,
  input  logic s1,
  input  logic s2,
  output logic y
);
  logic [7:0] in;
  assign in = {i7, i6, i5, i4, i3, i2, i1, i0};
  assign y = in[{s0, s1, s2}];
endmodule

// File: rtl/mux_scan_sequencer_dwell_counter.sv
// dwell_counter: CNT_W-bit counter (clk, rst_n, clr, en) flagging tc when it reaches DWELL-1
module dwell_counter #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (en) cnt <= cnt + CNT_W'(1);
  assign tc = cnt == CNT_W'(DWELL - 1);
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks mux select {s0,s1,s2} over 8 channels, samples mux_o into data, valid/ready out, busy when scanning
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mux_o,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       busy
);
  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shadow, shadow_n, data_n;
  logic       valid_n, tc;
  // the counter only runs in SETTLE, so it always enters SETTLE from zero
  dwell_counter #(.DWELL(DWELL), .CNT_W(CNT_W)) u_dwell (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state != ST_SETTLE),
    .en   (state == ST_SETTLE),
    .tc   (tc)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      shadow     <= '0;
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      shadow     <= shadow_n;
      data       <= data_n;
      data_valid <= valid_n;
    end
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    shadow_n = shadow;
    data_n   = data;
    valid_n  = data_valid;
    case (state)
      ST_IDLE: if (start) begin
        state_n = ST_SETTLE;
        idx_n   = '0;
      end
      ST_SETTLE: state_n = tc ? ST_SAMPLE : ST_SETTLE;
      ST_SAMPLE: begin
        shadow_n[idx] = mux_o;
        if (idx != 3'(NCH - 1)) begin
          idx_n   = idx + 3'd1;
          state_n = ST_SETTLE;
        end else begin
          data_n  = {mux_o, shadow[6:0]};
          valid_n = 1'b1;
          idx_n   = '0;
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: if (data_ready) begin
        valid_n = 1'b0;
        state_n = start ? ST_SETTLE : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end
  assign {s0, s1, s2} = idx;
  assign busy = state != ST_IDLE;
endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
Upstream/downstream companion to the 8-to-1 mux (mux_8to1) in the logic lab design. It drives the mux select lines {s0,s1,s2} through channels 0..7, holds each select for a settle window, and samples the mux output into a shadow register. The result is presented as an 8-bit word (bit k = input ik) on a valid/ready handshake. This turns the mux into a parallel-capture scanner for the lab top level.

Parameters:
DWELL, 4, cycles each select value is held before sampling; legal range 1..255.
CNT_W, 8, width of the dwell counter; must hold DWELL-1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
start  input  1  begin one 8-channel scan; sampled only in IDLE, or in HOLD on the cycle data_ready is high.
mux_o  input  1  output of the 8-to-1 mux.
s0  output  1  select MSB (index bit 2).
s1  output  1  select bit 1.
s2  output  1  select LSB (index bit 0); with {s0,s1,s2}=3'b001 the mux passes i1.
data  output  8  captured word; data[k] = mux_o sampled while index=k.
data_valid  output  1  data holds a completed scan not yet accepted.
data_ready  input  1  consumer accepts data on a cycle where data_valid && data_ready.
busy  output  1  high in SETTLE, SAMPLE and HOLD.

Behaviour:
- Reset is synchronous: when rst_n=0 at a clk edge, state=IDLE, idx=0, cnt=0, shadow=0, data=8'h00, data_valid=0, busy=0, {s0,s1,s2}=3'b000. Reset mid-scan discards the partial scan, and no valid is produced for it.
- {s0,s1,s2} are registered and equal idx in every state. In IDLE and HOLD, idx=0.
- FSM states: IDLE, SETTLE, SAMPLE, HOLD.
- IDLE: if start=1, then idx<=0, cnt<=0, go to SETTLE. Otherwise stay.
- SETTLE: cnt increments each cycle. When cnt==DWELL-1, go to SAMPLE. The select is therefore stable for DWELL full cycles before sampling.
- SAMPLE (1 cycle): shadow[idx]<=mux_o.
  - If idx!=7: idx<=idx+1, cnt<=0, go to SETTLE.
  - If idx==7: data<={mux_o,shadow[6:0]}, data_valid<=1, idx<=0, go to HOLD.
- HOLD: data and data_valid remain stable until data_ready=1. On a handshake, data_valid<=0.
  - If start=1 on that same cycle, go directly to SETTLE (back-to-back scans).
  - Otherwise go to IDLE.
- start is ignored in SETTLE and SAMPLE. It is not queued.
- data_ready is ignored when data_valid=0.
- data keeps the last accepted word until the next scan completes.
- Latency: from the edge where start is accepted to the edge where data_valid rises is exactly 8*(DWELL+1) cycles (40 for DWELL=4).
- Back-to-back throughput: one word per 8*(DWELL+1)+1 cycles.
- The mux is combinational, so mux_o is valid one cycle after a select change. DWELL>=1 guarantees this.
- Counter widths: idx is 3 bits and never wraps past 7 inside a scan. cnt is CNT_W bits and is compared with DWELL-1, truncated to CNT_W.

Decomposition:
- Shared package/header holds the state encoding localparams (ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_SAMPLE=2'd2, ST_HOLD=2'd3) and the channel count constant NCH=8.
- One natural sub-module, dwell_counter: CNT_W-bit counter with clear, enable and a terminal-count flag (cnt==DWELL-1).
- The FSM, the shadow register and the output register stay in the top module.
- The bench instantiates mux_scan_sequencer together with a real mux_8to1. The s0/s1/s2 outputs connect directly to the mux.

Test Plan:
1. Reset with rst_n=0 for 3 cycles, then release; toggle start while rst_n=0 -> all outputs 0, state IDLE, no scan starts.
2. Mux inputs i0..i7=0,1,0,1,0,1,0,1, DWELL=4, pulse start -> select walks 000..111 with each value held 5 cycles; data_valid rises 40 cycles after start; data=8'hAA.
3. Same scan with data_ready held low for 20 cycles -> data_valid and data=8'hAA stay stable for all 20 cycles; on data_ready=1, data_valid drops the next cycle and the FSM returns to IDLE.
4. Inputs changed to i0..i7=1,1,0,0,0,0,0,1; start held high through the HOLD handshake -> the second scan starts without passing through IDLE; second word is 8'h83 and follows 41 cycles after the first.
5. Pulse start again while at idx=3 in SETTLE -> ignored; the scan completes normally with exactly one data_valid.
6. Assert rst_n=0 for one cycle during SAMPLE at idx=5 -> next cycle all outputs are 0 and the FSM is in IDLE; a fresh start produces a correct full word, with no bits left over from the aborted scan.
